// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: computes {cout,sum} = a + b + cin one bit per clock
//   through a single 1-bit full adder, under a three-state controller
//   (IDLE -> RUN -> DONE -> IDLE).
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; accepted only in IDLE
//   a, b   in   WIDTH  unsigned operands, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while in RUN (WIDTH cycles)
//   done   out  1      one-cycle pulse in DONE, result valid
//   sum    out  WIDTH  registered result, held until the next accept
//   cout   out  1      registered final carry
// ---------------------------------------------------------------------------

// Single-bit full adder shared by every bit step.
module sac_fa (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ c;
  assign co = (x & y) | (x & c) | (y & c);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_l, b_l;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             fa_s, fa_co;
  logic             last_step;

  // Current bit of the latched operands feeds the one full adder.
  sac_fa u_fa (
    .x  (a_l[idx]),
    .y  (b_l[idx]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_step = (idx == IW'(WIDTH-1));

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  // start is only looked at in IDLE, so requests in RUN/DONE are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---- outputs decoded from state ----
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---- datapath ----
  // Operands are snapshotted at accept so later input changes cannot leak
  // into the result. The index stops at WIDTH-1 on the final step rather
  // than wrapping; it is reloaded to 0 on the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_l   <= '0;
      b_l   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_l   <= a;
            b_l   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
          end
        end
        RUN: begin
          sum[idx] <= fa_s;
          carry    <= fa_co;
          if (last_step) cout <= fa_co;
          else           idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
//   Stimulus pushes a + b + cin (plain integer add) into a per-instance queue;
//   a negedge monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance
  logic       rst8 = 1'b1, start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8;
  // WIDTH=2 instance
  logic       rst2 = 1'b1, start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic       busy2, done2, cout2;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic       prev_done8 = 1'b0, prev_done2 = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // ---- monitors ----
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst8 && done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8 unexpected done: got %0h want none", {cout8, sum8});
      end else begin
        e = q8.pop_front();
        chk("w8 result", {23'd0, cout8, sum8}, {23'd0, e});
      end
      chk("w8 busy low in done", {31'd0, busy8}, 32'd0);
      chk("w8 done one cycle", {31'd0, prev_done8}, 32'd0);
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst2 && done2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL w2 unexpected done: got %0h want none", {cout2, sum2});
      end else begin
        e = q2.pop_front();
        chk("w2 result", {29'd0, cout2, sum2}, {29'd0, e});
      end
      chk("w2 done one cycle", {31'd0, prev_done2}, 32'd0);
    end
    prev_done2 = done2;
  end

  // ---- WIDTH=8 helpers ----
  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (busy8 || done8) begin
      @(negedge clk);
      if (++n > 40) begin timeout("w8 wait idle"); return; end
    end
  endtask

  // mode 0: quiet, 1: random start/operand noise during RUN,
  // 2: operands zeroed and start pulsed at the third RUN cycle
  task automatic wait_done8(input int mode, output int cyc, output int busyc);
    cyc = 0; busyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy8) busyc++;
      if (done8) begin start8 = 1'b0; return; end
      if (cyc > 40) begin timeout("w8 wait done"); start8 = 1'b0; return; end
      start8 = 1'b0;
      if (mode == 1 && busy8) begin
        start8 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else if (mode == 2 && cyc == 3) begin
        a8 = 8'd0; b8 = 8'd0; start8 = 1'b1;
      end
    end
  endtask

  task automatic req8(input logic [7:0] a, input logic [7:0] b, input logic c, input int mode);
    int cyc, busyc;
    logic [8:0] e;
    wait_idle8();
    e = {1'b0, a} + {1'b0, b} + {8'd0, c};
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(e);
    wait_done8(mode, cyc, busyc);
    chk("w8 latency", cyc, 9);
    chk("w8 busy cycles", busyc, 8);
    @(negedge clk);
    chk("w8 result held", {23'd0, cout8, sum8}, {23'd0, e});
    chk("w8 idle after done", {30'd0, busy8, done8}, 32'd0);
  endtask

  initial begin
    int cyc, busyc, n;
    logic [8:0] e;
    logic [2:0] e2;

    repeat (2) @(negedge clk);
    chk("w8 reset busy/done", {30'd0, busy8, done8}, 32'd0);
    chk("w8 reset sum/cout", {23'd0, cout8, sum8}, 32'd0);
    rst8 = 1'b0; rst2 = 1'b0;

    // directed vectors
    req8(8'd3,   8'd5,   1'b0, 0);
    req8(8'd255, 8'd1,   1'b0, 0);
    req8(8'd255, 8'd255, 1'b1, 0);
    req8(8'd0,   8'd0,   1'b0, 0);
    // inputs changed and start re-pulsed mid-RUN must be ignored
    req8(8'd100, 8'd27,  1'b0, 2);
    repeat (15) begin
      @(negedge clk);
      chk("w8 no second done", {31'd0, done8}, 32'd0);
    end

    // reset at RUN step 4
    wait_idle8();
    a8 = 8'd170; b8 = 8'd85; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'd255);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w8 busy before abort", {31'd0, busy8}, 32'd1);
    #2 rst8 = 1'b1;
    #1;
    chk("w8 abort busy/done", {30'd0, busy8, done8}, 32'd0);
    chk("w8 abort sum/cout", {23'd0, cout8, sum8}, 32'd0);
    q8.delete();
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("w8 no done after abort", {30'd0, busy8, done8}, 32'd0);
    end
    req8(8'd170, 8'd85, 1'b0, 0);

    // start held high across reset release
    @(negedge clk);
    rst8 = 1'b1; a8 = 8'd37; b8 = 8'd200; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    q8.push_back(9'd238);
    rst8 = 1'b0;
    wait_done8(0, cyc, busyc);
    chk("w8 accept at release latency", cyc, 9);

    // start held continuously: back-to-back every WIDTH+2 cycles
    wait_idle8();
    a8 = 8'd1; b8 = 8'd1; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'd2);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done8 && n < 40);
      if (!done8) timeout("w8 held start");
      chk("w8 held start spacing", n, (k == 0) ? 9 : 10);
      if (k < 3) q8.push_back(9'd2);
      else       start8 = 1'b0;
    end

    // randomized sweep, WIDTH=8
    for (int i = 0; i < 500; i++)
      req8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 1)));

    // randomized sweep, WIDTH=2
    for (int i = 0; i < 500; i++) begin
      n = 0;
      @(negedge clk);
      while ((busy2 || done2) && n < 20) begin @(negedge clk); n++; end
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      e2 = {1'b0, a2} + {1'b0, b2} + {2'd0, cin2};
      q2.push_back(e2);
      start2 = 1'b1;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        start2 = busy2 ? 1'($urandom) : 1'b0;
        if (busy2) begin a2 = 2'($urandom); b2 = 2'($urandom); end
      end while (!done2 && cyc < 20);
      start2 = 1'b0;
      chk("w2 latency", cyc, 3);
    end

    repeat (5) @(negedge clk);
    chk("w8 scoreboard drained", q8.size(), 0);
    chk("w2 scoreboard drained", q2.size(), 0);
    e = 9'd0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global: watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
